// File: rtl/inst_enc_pkg.sv
// Shared types and range limits for the RV32I instruction encoder.
// Covers the format codes, the offset ranges and the stage-1 payload layout.
package inst_enc_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic signed [31:0] IMM12_MIN = -32'sd2048;
    localparam logic signed [31:0] IMM12_MAX = 32'sd2047;
    localparam logic signed [31:0] BOFF_MIN  = -32'sd4096;
    localparam logic signed [31:0] BOFF_MAX  = 32'sd4094;
    localparam logic signed [31:0] JOFF_MIN  = -32'sd1048576;
    localparam logic signed [31:0] JOFF_MAX  = 32'sd1048574;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] off;
    } s1_payload_t;

    function automatic logic in_range(input logic signed [31:0] v,
                                      input logic signed [31:0] lo,
                                      input logic signed [31:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Request/response bundle of the instruction encoder.
// The slave modport is the encoder's view; the master modport is the requester/consumer's view.
interface inst_encoder_if #(
    parameter int CNT_W = 16,
    parameter int ERR_W = 8
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic [2:0]        fmt_i;
    logic [6:0]        opcode_i;
    logic [4:0]        rd_i;
    logic [4:0]        rs1_i;
    logic [4:0]        rs2_i;
    logic [2:0]        funct3_i;
    logic [6:0]        funct7_i;
    logic [31:0]       imm_i;
    logic [31:0]       pc_i;
    logic              inst_valid_o;
    logic              inst_ready_i;
    logic [31:0]       inst_o;
    logic              err_o;
    logic [CNT_W-1:0]  enc_count_o;
    logic [ERR_W-1:0]  err_count_o;

    modport slave (
        input  req_valid_i, fmt_i, opcode_i, rd_i, rs1_i, rs2_i,
               funct3_i, funct7_i, imm_i, pc_i, inst_ready_i,
        output req_ready_o, inst_valid_o, inst_o, err_o,
               enc_count_o, err_count_o
    );

    modport master (
        output req_valid_i, fmt_i, opcode_i, rd_i, rs1_i, rs2_i,
               funct3_i, funct7_i, imm_i, pc_i, inst_ready_i,
        input  req_ready_o, inst_valid_o, inst_o, err_o,
               enc_count_o, err_count_o
    );

endinterface

// File: rtl/inst_pack.sv
// Combinational range check and RV32I word packing.
// An unencodable payload yields an all-zero word with the error flag set.
module inst_pack
    import inst_enc_pkg::*;
(
    input  s1_payload_t i_pl,
    output logic [31:0] o_inst,
    output logic        o_err
);

    logic [31:0] w_off;

    assign w_off = i_pl.off;

    // Select the format, validate the offset and scatter its bits.
    always_comb begin
        o_inst = 32'h0;
        o_err  = 1'b0;
        case (i_pl.fmt)
            FMT_R: begin
                o_inst = {i_pl.funct7, i_pl.rs2, i_pl.rs1, i_pl.funct3, i_pl.rd, i_pl.opcode};
            end
            FMT_I: begin
                if (in_range(w_off, IMM12_MIN, IMM12_MAX)) begin
                    o_inst = {w_off[11:0], i_pl.rs1, i_pl.funct3, i_pl.rd, i_pl.opcode};
                end else begin
                    o_err = 1'b1;
                end
            end
            FMT_S: begin
                if (in_range(w_off, IMM12_MIN, IMM12_MAX)) begin
                    o_inst = {w_off[11:5], i_pl.rs2, i_pl.rs1, i_pl.funct3, w_off[4:0], i_pl.opcode};
                end else begin
                    o_err = 1'b1;
                end
            end
            FMT_B: begin
                if (in_range(w_off, BOFF_MIN, BOFF_MAX) && (w_off[0] == 1'b0)) begin
                    o_inst = {w_off[12], w_off[10:5], i_pl.rs2, i_pl.rs1, i_pl.funct3,
                              w_off[4:1], w_off[11], i_pl.opcode};
                end else begin
                    o_err = 1'b1;
                end
            end
            FMT_U: begin
                if (w_off[11:0] == 12'h000) begin
                    o_inst = {w_off[31:12], i_pl.rd, i_pl.opcode};
                end else begin
                    o_err = 1'b1;
                end
            end
            FMT_J: begin
                if (in_range(w_off, JOFF_MIN, JOFF_MAX) && (w_off[0] == 1'b0)) begin
                    o_inst = {w_off[20], w_off[10:1], w_off[11], w_off[19:12], i_pl.rd, i_pl.opcode};
                end else begin
                    o_err = 1'b1;
                end
            end
            default: begin
                o_err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// Two-stage valid/ready RV32I instruction encoder with saturating statistics.
// S1 captures the request and branch/jump offset, S2 holds the packed word until consumed.
module inst_encoder
    import inst_enc_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int ERR_W = 8
) (
    input logic           clk_i,
    input logic           rst_ni,
    inst_encoder_if.slave bus
);

    s1_payload_t       w_req_pl;
    s1_payload_t       r_s1_pl;
    logic              r_s1_valid;
    logic              r_s2_valid;
    logic [31:0]       r_inst;
    logic              r_err;
    logic [CNT_W-1:0]  r_enc_cnt;
    logic [ERR_W-1:0]  r_err_cnt;
    logic              w_s2_adv;
    logic              w_s1_adv;
    logic              w_out_hs;
    logic [31:0]       w_inst;
    logic              w_err;

    assign w_s2_adv = !r_s2_valid || bus.inst_ready_i;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign w_out_hs = r_s2_valid && bus.inst_ready_i;

    assign bus.req_ready_o  = w_s1_adv;
    assign bus.inst_valid_o = r_s2_valid;
    assign bus.inst_o       = r_inst;
    assign bus.err_o        = r_err;
    assign bus.enc_count_o  = r_enc_cnt;
    assign bus.err_count_o  = r_err_cnt;

    // Assemble the request payload; branches and jumps carry a PC-relative offset.
    always_comb begin
        w_req_pl.fmt    = bus.fmt_i;
        w_req_pl.opcode = bus.opcode_i;
        w_req_pl.rd     = bus.rd_i;
        w_req_pl.rs1    = bus.rs1_i;
        w_req_pl.rs2    = bus.rs2_i;
        w_req_pl.funct3 = bus.funct3_i;
        w_req_pl.funct7 = bus.funct7_i;
        if ((bus.fmt_i == FMT_B) || (bus.fmt_i == FMT_J)) begin
            w_req_pl.off = bus.imm_i - bus.pc_i;
        end else begin
            w_req_pl.off = bus.imm_i;
        end
    end

    inst_pack u_pack (
        .i_pl   (r_s1_pl),
        .o_inst (w_inst),
        .o_err  (w_err)
    );

    // Stage 1: capture the request whenever the stage is free to move.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1_valid <= 1'b0;
            r_s1_pl    <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= bus.req_valid_i;
            if (bus.req_valid_i) begin
                r_s1_pl <= w_req_pl;
            end
        end
    end

    // Stage 2: register the packed word; it is frozen while the consumer stalls.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s2_valid <= 1'b0;
            r_inst     <= 32'h0;
            r_err      <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_inst <= w_inst;
                r_err  <= w_err;
            end
        end
    end

    // Statistics advance on each delivered word and stick at all-ones.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_enc_cnt <= '0;
            r_err_cnt <= '0;
        end else if (w_out_hs) begin
            if (r_enc_cnt != {CNT_W{1'b1}}) begin
                r_enc_cnt <= r_enc_cnt + CNT_W'(1);
            end
            if (r_err && (r_err_cnt != {ERR_W{1'b1}})) begin
                r_err_cnt <= r_err_cnt + ERR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: encodings, range limits, latency, stalls, reset and saturation.
module tb_inst_encoder;
    import inst_enc_pkg::*;

    localparam int CNT_W = 16;
    localparam int ERR_W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   exp_enc = 0;
    int   exp_err = 0;

    always #5 clk = ~clk;

    inst_encoder_if #(.CNT_W(CNT_W), .ERR_W(ERR_W)) bus ();

    inst_encoder #(.CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    task automatic idle_inputs;
        bus.req_valid_i  = 1'b0;
        bus.fmt_i        = 3'd0;
        bus.opcode_i     = 7'h0;
        bus.rd_i         = 5'd0;
        bus.rs1_i        = 5'd0;
        bus.rs2_i        = 5'd0;
        bus.funct3_i     = 3'd0;
        bus.funct7_i     = 7'h0;
        bus.imm_i        = 32'h0;
        bus.pc_i         = 32'h0;
        bus.inst_ready_i = 1'b0;
    endtask

    task automatic drive_req(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                             input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                             input logic [6:0] f7, input logic [31:0] imm, input logic [31:0] pc);
        bus.fmt_i       = fmt;
        bus.opcode_i    = op;
        bus.rd_i        = rd;
        bus.rs1_i       = rs1;
        bus.rs2_i       = rs2;
        bus.funct3_i    = f3;
        bus.funct7_i    = f7;
        bus.imm_i       = imm;
        bus.pc_i        = pc;
        bus.req_valid_i = 1'b1;
    endtask

    // add x<rd>, x1, x2
    task automatic drive_add(input logic [4:0] rd);
        drive_req(FMT_R, 7'h33, rd, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0, 32'h0);
    endtask

    task automatic pulse_reset;
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        exp_enc = 0;
        exp_err = 0;
    endtask

    task automatic single(input string name, input logic [2:0] fmt, input logic [6:0] op,
                          input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                          input logic [31:0] pc, input logic [31:0] exp_inst, input logic exp_e,
                          output int lat);
        @(negedge clk);
        drive_req(fmt, op, rd, rs1, rs2, f3, f7, imm, pc);
        bus.inst_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        bus.imm_i = ~imm;
        bus.pc_i  = ~pc;
        bus.rd_i  = ~rd;
        bus.fmt_i = 3'd7;
        lat = 1;
        while ((bus.inst_valid_o !== 1'b1) && (lat < 8)) begin
            @(negedge clk);
            lat++;
        end
        n_tests++;
        if (bus.inst_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_valid: inst_valid_o=%b after %0d cycles, required 1", name, bus.inst_valid_o, lat);
        end
        n_tests++;
        if ((bus.inst_o !== exp_inst) || (bus.err_o !== exp_e)) begin
            n_fail++;
            $display("FAIL %s_word: got inst=%h err=%b, required inst=%h err=%b",
                     name, bus.inst_o, bus.err_o, exp_inst, exp_e);
        end
        @(posedge clk);
        exp_enc++;
        if (exp_e && (exp_err < 255)) exp_err++;
        @(negedge clk);
        n_tests++;
        if ((bus.enc_count_o !== 16'(exp_enc)) || (bus.err_count_o !== 8'(exp_err)) ||
            (bus.inst_valid_o !== 1'b0)) begin
            n_fail++;
            $display("FAIL %s_counters: got enc=%0d err=%0d valid=%b, required enc=%0d err=%0d valid=0",
                     name, bus.enc_count_o, bus.err_count_o, bus.inst_valid_o, exp_enc, exp_err);
        end
    endtask

    task automatic test_reset;
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ((bus.req_ready_o !== 1'b1) || (bus.inst_valid_o !== 1'b0) || (bus.inst_o !== 32'h0) ||
            (bus.err_o !== 1'b0) || (bus.enc_count_o !== 16'h0) || (bus.err_count_o !== 8'h0)) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b vld=%b inst=%h err=%b enc=%0d errc=%0d, required 1 0 0 0 0 0",
                     bus.req_ready_o, bus.inst_valid_o, bus.inst_o, bus.err_o,
                     bus.enc_count_o, bus.err_count_o);
        end
        rst_n = 1'b1;
        exp_enc = 0;
        exp_err = 0;
    endtask

    task automatic test_encodings;
        int lat;
        single("addi", FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'hFFFF_FFFF, 32'h0, 32'hFFF0_0093, 1'b0, lat);
        n_tests++;
        if (lat !== 2) begin
            n_fail++;
            $display("FAIL addi_latency: got %0d cycles, required 2", lat);
        end
        single("beq", FMT_B, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 32'h108, 32'h100, 32'h0000_0463, 1'b0, lat);
        single("beq_odd", FMT_B, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 32'h109, 32'h100, 32'h0, 1'b1, lat);
        single("beq_back", FMT_B, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 32'hF8, 32'h100, 32'hFE00_0CE3, 1'b0, lat);
        single("jal", FMT_J, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'h800, 32'h0, 32'h0010_00EF, 1'b0, lat);
        single("lui", FMT_U, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h0, 32'h1234_5000, 32'h0, 32'h1234_52B7, 1'b0, lat);
        single("lui_low", FMT_U, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h0, 32'h1234_5001, 32'h0, 32'h0, 1'b1, lat);
        single("add", FMT_R, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h0, 32'hDEAD_BEEF, 32'h0, 32'h0020_81B3, 1'b0, lat);
        single("sw", FMT_S, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h0, 32'hFFFF_FFFC, 32'h0, 32'hFE20_AE23, 1'b0, lat);
    endtask

    task automatic test_boundaries;
        int lat;
        single("i_max", FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd2047, 32'h0, 32'h7FF0_0093, 1'b0, lat);
        single("i_min", FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'hFFFF_F800, 32'h0, 32'h8000_0093, 1'b0, lat);
        single("i_over", FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd2048, 32'h0, 32'h0, 1'b1, lat);
        single("b_max", FMT_B, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 32'hFFE, 32'h0, 32'h7E00_0FE3, 1'b0, lat);
        single("b_min", FMT_B, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 32'hFFFF_F000, 32'h0, 32'h8000_0063, 1'b0, lat);
        single("b_over", FMT_B, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 32'h1000, 32'h0, 32'h0, 1'b1, lat);
        single("j_over", FMT_J, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'h0010_0000, 32'h0, 32'h0, 1'b1, lat);
        single("fmt6", 3'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'h0, 32'h0, 32'h0, 1'b1, lat);
    endtask

    task automatic test_back_to_back;
        logic [31:0] w [4];
        int nxt;
        w[0] = 32'h0020_80B3;
        w[1] = 32'h0020_8133;
        w[2] = 32'h0020_81B3;
        w[3] = 32'h0020_8233;
        @(negedge clk);
        bus.inst_ready_i = 1'b0;
        drive_add(5'd1);
        n_tests++;
        if (bus.req_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_accept0: req_ready_o=%b, required 1", bus.req_ready_o);
        end
        @(posedge clk);
        @(negedge clk);
        drive_add(5'd2);
        n_tests++;
        if (bus.req_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_accept1: req_ready_o=%b, required 1", bus.req_ready_o);
        end
        @(posedge clk);
        @(negedge clk);
        drive_add(5'd3);
        for (int c = 0; c < 3; c++) begin
            n_tests++;
            if (bus.req_ready_o !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_ready_drop: req_ready_o=%b in stall cycle %0d, required 0", bus.req_ready_o, c);
            end
            n_tests++;
            if ((bus.inst_valid_o !== 1'b1) || (bus.inst_o !== w[0])) begin
                n_fail++;
                $display("FAIL bp_hold: got valid=%b inst=%h, required valid=1 inst=%h",
                         bus.inst_valid_o, bus.inst_o, w[0]);
            end
            @(posedge clk);
            @(negedge clk);
        end
        bus.inst_ready_i = 1'b1;
        nxt = 2;
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if ((bus.inst_valid_o !== 1'b1) || (bus.inst_o !== w[k]) || (bus.err_o !== 1'b0)) begin
                n_fail++;
                $display("FAIL bp_order%0d: got valid=%b inst=%h err=%b, required valid=1 inst=%h err=0",
                         k, bus.inst_valid_o, bus.inst_o, bus.err_o, w[k]);
            end
            @(posedge clk);
            exp_enc++;
            if (bus.req_valid_i) nxt++;
            @(negedge clk);
            if (nxt < 4) begin
                drive_add(5'(nxt + 1));
            end else begin
                bus.req_valid_i = 1'b0;
            end
        end
        n_tests++;
        if ((bus.inst_valid_o !== 1'b0) || (bus.enc_count_o !== 16'(exp_enc))) begin
            n_fail++;
            $display("FAIL bp_drain: got valid=%b enc=%0d, required valid=0 enc=%0d",
                     bus.inst_valid_o, bus.enc_count_o, exp_enc);
        end
    endtask

    task automatic test_reset_midstream;
        int lat;
        @(negedge clk);
        bus.inst_ready_i = 1'b0;
        drive_add(5'd7);
        @(posedge clk);
        @(negedge clk);
        drive_add(5'd8);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        n_tests++;
        if ((bus.inst_valid_o !== 1'b1) || (bus.req_ready_o !== 1'b0)) begin
            n_fail++;
            $display("FAIL rst_inflight: got valid=%b ready=%b, required valid=1 ready=0",
                     bus.inst_valid_o, bus.req_ready_o);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.inst_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async: inst_valid_o=%b, required 0", bus.inst_valid_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.inst_ready_i = 1'b1;
        exp_enc = 0;
        exp_err = 0;
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ((bus.inst_valid_o !== 1'b0) || (bus.enc_count_o !== 16'h0) || (bus.err_count_o !== 8'h0)) begin
            n_fail++;
            $display("FAIL rst_cleared: got valid=%b enc=%0d err=%0d, required 0 0 0",
                     bus.inst_valid_o, bus.enc_count_o, bus.err_count_o);
        end
        single("post_rst", FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'hFFFF_FFFF, 32'h0, 32'hFFF0_0093, 1'b0, lat);
    endtask

    task automatic test_saturation;
        pulse_reset();
        bus.inst_ready_i = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            drive_req(3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'h0, 32'h0);
            @(posedge clk);
        end
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ((bus.enc_count_o !== 16'd300) || (bus.err_count_o !== 8'd255)) begin
            n_fail++;
            $display("FAIL saturation: got enc=%0d err=%0d, required enc=300 err=255",
                     bus.enc_count_o, bus.err_count_o);
        end
    endtask

    initial begin
        test_reset();
        test_encodings();
        test_boundaries();
        test_back_to_back();
        test_reset_midstream();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
